// File: rtl/instr_align_if.sv
// Fetch-side and decode-side handshake bundle for instr_align.
// The master drives fetch words in and accepts instructions; the slave is the aligner.
interface instr_align_if #(
  parameter int PC_WIDTH = 24
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_data;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_instr;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_len32;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_pc,
    output out_len32
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_len32
  );
endinterface

// File: rtl/instr_align.sv
// Parcel aligner between fetch and decode: buffers 16-bit parcels, emits 16/32-bit instrs.
// Optional perf/stall counters under INSTR_ALIGN_PERF_EN.
module instr_align #(
  parameter int PC_WIDTH = 24,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
`ifdef INSTR_ALIGN_PERF_EN
  output logic [31:0]         perf_count,
  output logic [31:0]         stall_count,
`endif
  instr_align_if.slave        bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]         buf_q [DEPTH];
  logic [PW-1:0]       head_q;
  logic [PW-1:0]       tail_q;
  logic [CW-1:0]       count_q;
  logic                skip_q;
  logic [PC_WIDTH-1:0] pc_q;

  logic [PW-1:0] head_nx;
  logic [PW-1:0] tail_nx;
  logic [15:0]   p0;
  logic [15:0]   p1;
  logic          valid_raw;
  logic          accept;
  logic          fire;
  logic [1:0]    enq;
  logic [1:0]    deq;

  assign head_nx = head_q + PW'(1);
  assign tail_nx = tail_q + PW'(1);
  assign p0      = buf_q[head_q];
  assign p1      = buf_q[head_nx];

  always_comb begin
    valid_raw     = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_len32 = 1'b0;
    bus.out_instr = 32'h0;
    bus.out_pc    = pc_q;
    accept        = 1'b0;
    fire          = 1'b0;
    enq           = 2'd0;
    deq           = 2'd0;

    // A lone 32-bit prefix at head never counts as a complete instruction.
    valid_raw     = ((count_q != '0) && !p0[15]) ||
                    (count_q >= CW'(2));
    bus.in_ready  = (CW'(DEPTH) - count_q) >= CW'(2);
    bus.out_valid = valid_raw && !redirect;
    bus.out_len32 = p0[15];
    bus.out_instr = p0[15] ? {p0, p1} : {p0, 16'h0000};

    accept = bus.in_valid && bus.in_ready && !redirect;
    fire   = bus.out_valid && bus.out_ready;
    if (accept) enq = skip_q ? 2'd1 : 2'd2;
    if (fire)   deq = p0[15] ? 2'd2 : 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 16'h0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      skip_q  <= 1'b0;
      pc_q    <= '0;
    end else if (redirect) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      skip_q  <= redirect_pc[0];
      pc_q    <= redirect_pc;
    end else begin
      if (accept) begin
        if (skip_q) begin
          buf_q[tail_q] <= bus.in_data[31:16];
          tail_q        <= tail_nx;
          skip_q        <= 1'b0;
        end else begin
          buf_q[tail_q]  <= bus.in_data[15:0];
          buf_q[tail_nx] <= bus.in_data[31:16];
          tail_q         <= tail_q + PW'(2);
        end
      end
      if (fire) begin
        head_q <= head_q + PW'(deq);
        pc_q   <= pc_q + PC_WIDTH'(deq);
      end
      count_q <= count_q + CW'(enq) - CW'(deq);
    end
  end

`ifdef INSTR_ALIGN_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_count <= 32'h0;
    end else if (redirect) begin
      perf_count <= 32'h0;
    end else if (fire) begin
      perf_count <= perf_count + 32'h1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 32'h0;
    end else if ((count_q != '0) && !bus.out_valid) begin
      stall_count <= stall_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_align.sv
// Directed self-checking bench for instr_align.
// Each task drives one scenario and compares against hand-computed values.
module tb_instr_align;
  localparam int PCW = 24;

  logic           clk;
  logic           rst_n;
  logic           redirect;
  logic [PCW-1:0] redirect_pc;
`ifdef INSTR_ALIGN_PERF_EN
  logic [31:0]    perf_count;
  logic [31:0]    stall_count;
`endif

  int total;
  int passed;

  instr_align_if #(.PC_WIDTH(PCW)) bus ();

  instr_align #(.PC_WIDTH(PCW), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
`ifdef INSTR_ALIGN_PERF_EN
    .perf_count  (perf_count),
    .stall_count (stall_count),
`endif
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [PCW-1:0] pc);
    redirect     = 1'b1;
    redirect_pc  = pc;
    bus.in_valid = 1'b0;
    step();
    redirect     = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] ins,
                         input logic [PCW-1:0] pc, input logic l32);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== ins ||
        bus.out_pc !== pc || bus.out_len32 !== l32)
      $display("FAIL %s: got v=%b instr=%h pc=%h len32=%b want v=1 instr=%h pc=%h len32=%b",
               nm, bus.out_valid, bus.out_instr, bus.out_pc, bus.out_len32,
               ins, pc, l32);
    else passed++;
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic want);
    total++;
    if (got !== want)
      $display("FAIL %s: got %b want %b", nm, got, want);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_instr !== 32'h0 || bus.out_pc !== '0 ||
        bus.out_len32 !== 1'b0)
      $display("FAIL reset: v=%b rdy=%b instr=%h pc=%h len32=%b want 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.out_instr, bus.out_pc,
               bus.out_len32);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_redirect(24'h000100);
    bus.out_ready = 1'b1;
    push(32'h0002_0001);
    chk_out("basic0", 32'h0001_0000, 24'h000100, 1'b0);
    step();
    chk_out("basic1", 32'h0002_0000, 24'h000101, 1'b0);
    step();
    chk_bit("basic_empty", bus.out_valid, 1'b0);
`ifdef INSTR_ALIGN_PERF_EN
    total++;
    if (perf_count !== 32'd2)
      $display("FAIL perf_basic: got %0d want 2", perf_count);
    else passed++;
`endif
  endtask

  task automatic test_straddle();
    do_redirect(24'h000200);
    bus.out_ready = 1'b1;
    push(32'h8123_0005);
    chk_out("strad0", 32'h0005_0000, 24'h000200, 1'b0);
    step();
    chk_bit("strad_wait", bus.out_valid, 1'b0);
    push(32'h0007_4567);
    chk_out("strad32", 32'h8123_4567, 24'h000201, 1'b1);
    step();
    chk_out("strad_tail", 32'h0007_0000, 24'h000203, 1'b0);
    step();
    chk_bit("strad_empty", bus.out_valid, 1'b0);
  endtask

  task automatic test_odd_redirect();
    do_redirect(24'h000301);
    bus.out_ready = 1'b1;
    push(32'h0009_0008);
    chk_out("odd0", 32'h0009_0000, 24'h000301, 1'b0);
    step();
    chk_bit("odd_no_p0", bus.out_valid, 1'b0);
  endtask

  task automatic test_back_pressure();
    do_redirect(24'h000400);
    bus.out_ready = 1'b0;
    push(32'h0012_0011);
    chk_bit("bp_rdy_c2", bus.in_ready, 1'b1);
    push(32'h0014_0013);
    chk_bit("bp_rdy_c4", bus.in_ready, 1'b0);
    chk_out("bp_hold0", 32'h0011_0000, 24'h000400, 1'b0);
    push(32'h0016_0015);
    chk_out("bp_hold1", 32'h0011_0000, 24'h000400, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("bp_drain%0d", i), {16'(32'h11 + i), 16'h0},
              24'h000400 + 24'(i), 1'b0);
      step();
    end
    chk_bit("bp_empty", bus.out_valid, 1'b0);
  endtask

  task automatic test_redirect_mid();
    do_redirect(24'h000501);
    bus.out_ready = 1'b0;
    push(32'h0022_0021);
    push(32'h0024_0023);
    chk_out("rd_pre", 32'h0022_0000, 24'h000501, 1'b0);
    redirect      = 1'b1;
    redirect_pc   = 24'h000600;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0026_0025;
    bus.out_ready = 1'b1;
    #1;
    chk_bit("rd_forced_low", bus.out_valid, 1'b0);
    step();
    redirect     = 1'b0;
    bus.in_valid = 1'b0;
    chk_bit("rd_after_v", bus.out_valid, 1'b0);
    chk_bit("rd_after_rdy", bus.in_ready, 1'b1);
    total++;
    if (bus.out_pc !== 24'h000600)
      $display("FAIL rd_pc: got %h want 000600", bus.out_pc);
    else passed++;
    push(32'h0031_0030);
    chk_out("rd_new", 32'h0030_0000, 24'h000600, 1'b0);
    step();
    chk_out("rd_new1", 32'h0031_0000, 24'h000601, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    do_redirect(24'h000701);
    bus.out_ready = 1'b1;
    push(32'h8040_0000);
    chk_bit("rm_prefix_held", bus.out_valid, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("rm_v", bus.out_valid, 1'b0);
    chk_bit("rm_rdy", bus.in_ready, 1'b1);
    total++;
    if (bus.out_instr !== 32'h0 || bus.out_pc !== '0)
      $display("FAIL rm_regs: got instr=%h pc=%h want 0 0",
               bus.out_instr, bus.out_pc);
    else passed++;
`ifdef INSTR_ALIGN_PERF_EN
    total++;
    if (perf_count !== 32'd0)
      $display("FAIL rm_perf: got %0d want 0", perf_count);
    else passed++;
`endif
    step();
    rst_n = 1'b1;
    step();
    do_redirect(24'h000800);
    push(32'h0052_0051);
    chk_out("rm_fresh", 32'h0051_0000, 24'h000800, 1'b0);
    step();
  endtask

  initial begin
    total         = 0;
    passed        = 0;
    rst_n         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_straddle();
    test_odd_redirect();
    test_back_pressure();
    test_redirect_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/instr_align.md
Name: instr_align

Overview:
- Fetch-side alignment stage directly upstream of the combinational instruction decoder.
- Accepts 32-bit fetch words, each holding two 16-bit parcels, and buffers the parcels.
- Emits one complete 16- or 32-bit instruction per handshake in the decoder's instr[31:0] layout, with its parcel-address PC.
- Handles instructions that straddle fetch words, back-pressure, and branch redirects into odd parcels.

Parameters:
PC_WIDTH, 24, width of parcel (16-bit word) address
DEPTH, 4, parcel buffer entries; power of two, >= 4

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
redirect  input  1  flush buffer and restart at redirect_pc
redirect_pc  input  PC_WIDTH  new parcel address; bit 0 set = start at odd parcel
in_valid  input  1  fetch word available
in_ready  output  1  stage can accept a fetch word
in_data  input  32  parcel0 = [15:0] (lower address), parcel1 = [31:16]
out_valid  output  1  complete instruction available
out_ready  input  1  decode stage accepts instruction
out_instr  output  32  aligned instruction for decoder
out_pc  output  PC_WIDTH  parcel address of instruction's first parcel
out_len32  output  1  instruction is 32-bit

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - buffer count = 0, so out_valid = 0 and in_ready = 1.
  - out_instr = 0, out_pc = 0, out_len32 = 0.
  - skip flag = 0, pc register = 0.
- Parcel classification: a parcel with bit 15 = 1 is the first parcel of a 32-bit instruction. Any other parcel is a complete 16-bit instruction.
- Instruction layout:
  - 16-bit: out_instr = {p0, 16'h0000}.
  - 32-bit: out_instr = {p0, p1}, where p0 is the first parcel and p1 the next parcel, taken verbatim.
- out_len32 = p0[15].
- Buffer: circular FIFO of DEPTH parcels with head/tail pointers and a count; pointers wrap modulo DEPTH.
- Input handshake:
  - in_ready = (DEPTH - count) >= 2, computed from the registered count only (no same-cycle dequeue credit).
  - A word is accepted when in_valid && in_ready. Both parcels are enqueued, parcel0 first.
  - Exception: when the skip flag is set, only parcel1 is enqueued and the skip flag clears.
- Output handshake:
  - out_valid = (count >= 1 && !head[15]) || count >= 2.
  - out_instr, out_pc and out_len32 are driven combinationally from the buffer head and head+1; they are stable while out_valid && !out_ready.
  - When out_valid && out_ready, dequeue 1 or 2 parcels (2 when out_len32) and advance pc by the same amount, modulo 2^PC_WIDTH.
  - A 32-bit instruction whose second parcel has not arrived holds out_valid = 0.
- Simultaneous enqueue and dequeue: count_next = count + enq - deq, where enq is 0/1/2 and deq is 0/1/2.
- Latency: a word accepted in cycle N can produce out_valid in cycle N+1.
- Redirect has priority over everything:
  - On redirect = 1: count <= 0, pointers <= 0, pc <= redirect_pc, skip flag <= redirect_pc[0].
  - Any in_data offered that cycle is dropped. Any output handshake that cycle is ignored: out_valid is forced to 0 during redirect.
  - The fetch unit is responsible for supplying the word containing redirect_pc next.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no partial instruction is retained.
- A prefix parcel with bit 15 = 1 sitting at head when count = 1 is never emitted as a 16-bit instruction.

Optional Feature:
- Macro: INSTR_ALIGN_PERF_EN.
- With the macro defined:
  - Adds output port perf_count (32 bits), reset to 0.
  - perf_count increments by 1 on every output handshake and wraps at 2^32.
  - redirect clears perf_count to 0 in the same cycle.
  - Adds output stall_count (32 bits), incremented each cycle in which count >= 1 && !out_valid (waiting for a second parcel).
- Without the macro: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset, then redirect_pc = 0x000100 and word 0x0002_0001 with out_ready = 1 -> instr 0x0001_0000 at pc 0x100, then 0x0002_0000 at pc 0x101; len32 = 0 for both.
- Straddle: after redirect_pc = 0x000200, words 0x8123_0005 then 0x0007_4567 -> 0x0005_0000 (pc 0x200); out_valid low until second word; then 0x8123_4567, len32 = 1 (pc 0x201); then 0x0007_0000 (pc 0x203).
- Odd redirect: redirect_pc = 0x000301, word 0x0009_0008 -> only 0x0009_0000 at pc 0x301; parcel 0x0008 never emitted.
- Back-pressure: out_ready = 0 while streaming 16-bit words -> in_ready falls after 2 words (count = 4), out_instr held stable; release -> all 4 instructions in order, no loss or duplication.
- Redirect with count = 3, in_valid = 1 and out_ready = 1 in the same cycle -> no handshake; next cycle count = 0, out_valid = 0, pc = redirect_pc.
- rst_n pulsed low mid-32-bit-instruction with one parcel buffered -> out_valid = 0, in_ready = 1 immediately; with INSTR_ALIGN_PERF_EN, perf_count = 0.
